// File: rtl/eth_payload_bridge_if.sv
// eth_payload_bridge_if: MAC-side RX/TX streams and handler-side byte interfaces of the bridge
interface eth_payload_bridge_if;
    logic [7:0] i_rx_data;
    logic       i_rx_valid;
    logic       i_rx_last;
    logic       i_rx_err;
    logic       o_rx_drop;
    logic [7:0] o_rdata;
    logic       o_rready;
    logic       i_rreq;
    logic [7:0] i_wdata;
    logic       i_wvalid;
    logic       o_wready;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       o_tx_last;
    logic       i_tx_ready;
    modport slave (
        input  i_rx_data, i_rx_valid, i_rx_last, i_rx_err, i_rreq, i_wdata, i_wvalid, i_tx_ready,
        output o_rx_drop, o_rdata, o_rready, o_wready, o_tx_data, o_tx_valid, o_tx_last
    );
    modport master (
        output i_rx_data, i_rx_valid, i_rx_last, i_rx_err, i_rreq, i_wdata, i_wvalid, i_tx_ready,
        input  o_rx_drop, o_rdata, o_rready, o_wready, o_tx_data, o_tx_valid, o_tx_last
    );
endinterface

// File: rtl/eth_payload_bridge.sv
// eth_payload_bridge: buffers whole RX frames for the handler and frames handler bytes for MAC TX
module eth_payload_bridge #(
    parameter int RX_AW = 8,
    parameter int TX_AW = 6
) (
    input logic i_clk,
    input logic i_rst,
    eth_payload_bridge_if.slave bus
);
    localparam logic [RX_AW:0] RDEPTH = (RX_AW+1)'(1) << RX_AW;
    localparam logic [TX_AW:0] TDEPTH = (TX_AW+1)'(1) << TX_AW;
    typedef enum logic [1:0] {IDLE, FILL, SEND} st_t;
    logic [7:0] rmem_q [2**RX_AW];
    logic [7:0] tmem_q [2**TX_AW];
    logic [RX_AW:0] rwr_q, rwr_d, rcwr_q, rcwr_d, rrd_q, rrd_d, rcnt, rwr_inc;
    logic ovf_q, ovf_d, drop_q, drop_d, rready_q, rready_d;
    logic [7:0] rdata_q, rdata_d;
    logic rfull, rx_we, rx_end, bad, pop;
    st_t state_q, state_d;
    logic [TX_AW:0] twr_q, twr_d, trd_q, trd_d, tcnt;
    logic [7:0] tx_data_q, tx_data_d;
    logic tx_valid_q, tx_valid_d, tx_last_q, tx_last_d;
    logic wready, wacc, closes, acc, ld;
    always_comb begin
        rcnt = rwr_q - rrd_q;
        rfull = rcnt == RDEPTH;
        rx_we = bus.i_rx_valid && !rfull && !ovf_q;
        rx_end = bus.i_rx_valid && bus.i_rx_last;
        bad = bus.i_rx_err || ovf_q || rfull;
        rwr_inc = rwr_q + (RX_AW+1)'(rx_we);
        ovf_d = rx_end ? 1'b0 : ovf_q || (bus.i_rx_valid && rfull);
        rwr_d = (rx_end && bad) ? rcwr_q : rwr_inc;
        rcwr_d = (rx_end && !bad) ? rwr_inc : rcwr_q;
        drop_d = rx_end && bad;
        pop = bus.i_rreq && rready_q && (rrd_q != rcwr_q);
        rrd_d = rrd_q + (RX_AW+1)'(pop);
        rdata_d = pop ? rmem_q[rrd_q[RX_AW-1:0]] : rdata_q;
        rready_d = rrd_q != rcwr_q;
    end
    always_comb begin
        tcnt = twr_q - trd_q;
        wready = !i_rst && (state_q == IDLE || (state_q == FILL && tcnt != TDEPTH));
        wacc = bus.i_wvalid && wready;
        closes = wacc && (tcnt + (TX_AW+1)'(1) == TDEPTH);
        acc = tx_valid_q && bus.i_tx_ready;
    end
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: state_d = wacc ? (closes ? SEND : FILL) : IDLE;
            FILL: state_d = (!bus.i_wvalid || closes) ? SEND : FILL;
            SEND: state_d = (acc && tx_last_q) ? IDLE : SEND;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        ld = state_q == SEND && (!tx_valid_q || (acc && !tx_last_q)) && tcnt != '0;
        tx_valid_d = ld || (tx_valid_q && !acc);
        tx_last_d = ld ? tcnt == (TX_AW+1)'(1) : tx_last_q && !acc;
        tx_data_d = ld ? tmem_q[trd_q[TX_AW-1:0]] : tx_data_q;
        trd_d = trd_q + (TX_AW+1)'(ld);
        twr_d = twr_q + (TX_AW+1)'(wacc);
    end
    always_ff @(posedge i_clk) begin
        if (rx_we) rmem_q[rwr_q[RX_AW-1:0]] <= bus.i_rx_data;
        if (wacc) tmem_q[twr_q[TX_AW-1:0]] <= bus.i_wdata;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rwr_q <= '0;
            rcwr_q <= '0;
            rrd_q <= '0;
            ovf_q <= 1'b0;
            drop_q <= 1'b0;
            rready_q <= 1'b0;
            rdata_q <= '0;
            twr_q <= '0;
            trd_q <= '0;
            tx_data_q <= '0;
            tx_valid_q <= 1'b0;
            tx_last_q <= 1'b0;
        end else begin
            rwr_q <= rwr_d;
            rcwr_q <= rcwr_d;
            rrd_q <= rrd_d;
            ovf_q <= ovf_d;
            drop_q <= drop_d;
            rready_q <= rready_d;
            rdata_q <= rdata_d;
            twr_q <= twr_d;
            trd_q <= trd_d;
            tx_data_q <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q <= tx_last_d;
        end
    end
    assign bus.o_rx_drop = drop_q;
    assign bus.o_rdata = rdata_q;
    assign bus.o_rready = rready_q;
    assign bus.o_wready = wready;
    assign bus.o_tx_data = tx_data_q;
    assign bus.o_tx_valid = tx_valid_q;
    assign bus.o_tx_last = tx_last_q;
endmodule

// File: tb/tb_eth_payload_bridge.sv
// tb_eth_payload_bridge: directed checks of RX commit/drop/overflow and TX framing/backpressure/reset
module tb_eth_payload_bridge;
    logic clk = 1'b0;
    logic rst;
    int tests = 0;
    int fails = 0;
    eth_payload_bridge_if bus();
    eth_payload_bridge #(.RX_AW(2), .TX_AW(2)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask
    task automatic rx_byte(input logic [7:0] d, input logic l, input logic e);
        bus.i_rx_data = d;
        bus.i_rx_valid = 1'b1;
        bus.i_rx_last = l;
        bus.i_rx_err = e;
        @(negedge clk);
        bus.i_rx_valid = 1'b0;
        bus.i_rx_last = 1'b0;
        bus.i_rx_err = 1'b0;
    endtask
    task automatic put(input logic [7:0] d);
        int n = 0;
        bus.i_wdata = d;
        bus.i_wvalid = 1'b1;
        while (!bus.o_wready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("put_wready", bus.o_wready, 1);
        @(negedge clk);
    endtask
    task automatic get(input logic [7:0] d, input logic l, input logic stall);
        int n = 0;
        bus.i_tx_ready = 1'b0;
        while (!bus.o_tx_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("tx_valid", bus.o_tx_valid, 1);
        if (stall) begin
            chk("tx_data_pre_stall", bus.o_tx_data, d);
            @(negedge clk);
            chk("tx_valid_stall", bus.o_tx_valid, 1);
        end
        chk("tx_data", bus.o_tx_data, d);
        chk("tx_last", bus.o_tx_last, l);
        bus.i_tx_ready = 1'b1;
        @(negedge clk);
        bus.i_tx_ready = 1'b0;
    endtask
    initial begin
        int resid;
        rst = 1'b1;
        bus.i_rx_data = '0;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_last = 1'b0;
        bus.i_rx_err = 1'b0;
        bus.i_rreq = 1'b0;
        bus.i_wdata = '0;
        bus.i_wvalid = 1'b0;
        bus.i_tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rdata", bus.o_rdata, 0);
        chk("rst_rready", bus.o_rready, 0);
        chk("rst_drop", bus.o_rx_drop, 0);
        chk("rst_wready", bus.o_wready, 0);
        chk("rst_tx_data", bus.o_tx_data, 0);
        chk("rst_tx_valid", bus.o_tx_valid, 0);
        chk("rst_tx_last", bus.o_tx_last, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_wready", bus.o_wready, 1);
        rx_byte(8'h11, 0, 0);
        rx_byte(8'h22, 0, 0);
        rx_byte(8'h33, 1, 0);
        chk("good_drop", bus.o_rx_drop, 0);
        chk("rready_commit_cycle", bus.o_rready, 0);
        @(negedge clk);
        chk("rready_rise", bus.o_rready, 1);
        bus.i_rreq = 1'b1;
        @(negedge clk);
        chk("pop0", bus.o_rdata, 8'h11);
        @(negedge clk);
        chk("pop1", bus.o_rdata, 8'h22);
        @(negedge clk);
        chk("pop2", bus.o_rdata, 8'h33);
        bus.i_rreq = 1'b0;
        @(negedge clk);
        chk("rready_fall", bus.o_rready, 0);
        for (int k = 0; k < 4; k++) rx_byte(8'h40 + 8'(k), k == 3, k == 3);
        chk("bad_drop", bus.o_rx_drop, 1);
        chk("bad_rready", bus.o_rready, 0);
        @(negedge clk);
        chk("bad_drop_once", bus.o_rx_drop, 0);
        chk("bad_rready_late", bus.o_rready, 0);
        rx_byte(8'hA5, 1, 0);
        @(negedge clk);
        chk("a5_rready", bus.o_rready, 1);
        bus.i_rreq = 1'b1;
        @(negedge clk);
        bus.i_rreq = 1'b0;
        chk("a5_data", bus.o_rdata, 8'hA5);
        @(negedge clk);
        chk("a5_rready_fall", bus.o_rready, 0);
        for (int k = 0; k < 6; k++) rx_byte(8'h80 + 8'(k), k == 5, 1'b0);
        chk("ovf_drop", bus.o_rx_drop, 1);
        @(negedge clk);
        chk("ovf_rready", bus.o_rready, 0);
        chk("ovf_drop_once", bus.o_rx_drop, 0);
        rx_byte(8'h01, 0, 0);
        rx_byte(8'h02, 1, 0);
        @(negedge clk);
        chk("post_ovf_rready", bus.o_rready, 1);
        bus.i_rreq = 1'b1;
        @(negedge clk);
        chk("post_ovf_b0", bus.o_rdata, 8'h01);
        @(negedge clk);
        chk("post_ovf_b1", bus.o_rdata, 8'h02);
        bus.i_rreq = 1'b0;
        @(negedge clk);
        chk("post_ovf_empty", bus.o_rready, 0);
        bus.i_rreq = 1'b1;
        @(negedge clk);
        bus.i_rreq = 1'b0;
        chk("empty_pop_hold", bus.o_rdata, 8'h02);
        put(8'h5A);
        bus.i_wvalid = 1'b0;
        chk("single_fill_wready", bus.o_wready, 1);
        @(negedge clk);
        chk("single_send_wready", bus.o_wready, 0);
        get(8'h5A, 1, 0);
        chk("single_after_wready", bus.o_wready, 1);
        chk("single_after_valid", bus.o_tx_valid, 0);
        for (int k = 0; k < 4; k++) put(8'(k));
        bus.i_wdata = 8'h04;
        chk("full_send_wready", bus.o_wready, 0);
        get(8'h00, 0, 1);
        get(8'h01, 0, 0);
        get(8'h02, 0, 1);
        get(8'h03, 1, 1);
        chk("full_after_wready", bus.o_wready, 1);
        put(8'h04);
        put(8'h05);
        bus.i_wvalid = 1'b0;
        get(8'h04, 0, 0);
        get(8'h05, 1, 0);
        for (int k = 0; k < 4; k++) put(8'hC0 + 8'(k));
        bus.i_wvalid = 1'b0;
        get(8'hC0, 0, 0);
        get(8'hC1, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_tx_valid", bus.o_tx_valid, 0);
        chk("mid_rst_tx_data", bus.o_tx_data, 0);
        chk("mid_rst_tx_last", bus.o_tx_last, 0);
        chk("mid_rst_wready", bus.o_wready, 0);
        chk("mid_rst_rdata", bus.o_rdata, 0);
        chk("mid_rst_rready", bus.o_rready, 0);
        rst = 1'b0;
        bus.i_tx_ready = 1'b1;
        resid = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.o_tx_valid) resid++;
        end
        bus.i_tx_ready = 1'b0;
        chk("residual_beats", 9'(resid), 0);
        chk("post_rst_wready", bus.o_wready, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
